multimode_counter: RTL and testbench

//  Next-generation multi-mode counter: binary, Gray, ring and Johnson sequences, up/down, sync load.

---
 rtl/multimode_counter.sv | 152 +++++++++++++++
 tb/tb_multimode_counter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_counter.sv
// Multi-mode counter with binary, Gray, ring and Johnson sequences, up/down, synchronous load,
// a modulo limit for binary/Gray, optional saturation, a wrap pulse and ring/Johnson illegal-state recovery.
module multimode_counter #(
    parameter int COUNT_WIDTH = 8,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   count_dir,
    input  logic                   count_enable_,
    input  logic [1:0]             count_type,
    input  logic                   load_,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic [COUNT_WIDTH-1:0] count_limit,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   wrap,
    output logic                   illegal
);

    localparam int W = COUNT_WIDTH;
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_RING = 2'b10,
        MODE_JOHN = 2'b11
    } mode_t;

    mode_t          mode_q;
    logic [W-1:0]   count_nxt;
    logic           wrap_nxt;
    logic           illegal_nxt;
    logic [W:0]     bin_res;
    logic [W:0]     gray_res;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Returns {wrap, next}; values above the limit wrap on the way up and decrement on the way down.
    function automatic logic [W:0] bin_step(input logic [W-1:0] cur,
                                            input logic [W-1:0] lim,
                                            input logic         up);
        logic [W:0] r;
        if (up) begin
            if (cur >= lim) r = SATURATE ? {1'b0, cur} : {1'b1, ZERO};
            else            r = {1'b0, cur + ONE};
        end else begin
            if (cur == ZERO) r = SATURATE ? {1'b0, ZERO} : {1'b1, lim};
            else             r = {1'b0, cur - ONE};
        end
        return r;
    endfunction

    function automatic logic ring_legal(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    // A Johnson code has at most one boundary between adjacent bits.
    function automatic logic john_legal(input logic [W-1:0] v);
        logic [W-1:0] t;
        int           n;
        t = v ^ (v >> 1);
        n = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (t[i]) n++;
        end
        return (n <= 1);
    endfunction

    function automatic logic [W-1:0] seed(input logic [1:0] m);
        return (m == MODE_RING) ? ONE : ZERO;
    endfunction

    assign bin_res  = bin_step(count, count_limit, count_dir);
    assign gray_res = bin_step(from_gray(count), count_limit, count_dir);

    always_comb begin
        count_nxt   = count;
        wrap_nxt    = 1'b0;
        illegal_nxt = 1'b0;
        if (!load_) begin
            count_nxt = load_val;
        end else if (count_type != mode_q) begin
            count_nxt = seed(count_type);
        end else if (!count_enable_) begin
            case (mode_q)
                MODE_BIN: begin
                    count_nxt = bin_res[W-1:0];
                    wrap_nxt  = bin_res[W];
                end
                MODE_GRAY: begin
                    count_nxt = to_gray(gray_res[W-1:0]);
                    wrap_nxt  = gray_res[W];
                end
                MODE_RING: begin
                    if (!ring_legal(count)) begin
                        count_nxt   = ONE;
                        illegal_nxt = 1'b1;
                    end else if (count_dir) begin
                        count_nxt = {count[0], count[W-1:1]};
                        wrap_nxt  = count[0];
                    end else begin
                        count_nxt = {count[W-2:0], count[W-1]};
                        wrap_nxt  = count[W-1];
                    end
                end
                default: begin
                    if (!john_legal(count)) begin
                        count_nxt   = ZERO;
                        illegal_nxt = 1'b1;
                    end else begin
                        count_nxt = count_dir ? {~count[0], count[W-1:1]}
                                              : {count[W-2:0], ~count[W-1]};
                        wrap_nxt  = (count_nxt == ZERO);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            count   <= '0;
            wrap    <= 1'b0;
            illegal <= 1'b0;
            mode_q  <= MODE_BIN;
        end else begin
            count   <= count_nxt;
            wrap    <= wrap_nxt;
            illegal <= illegal_nxt;
            mode_q  <= mode_t'(count_type);
        end
    end

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: wrapping and saturating instances driven in parallel, checked against
// directed vectors, hand sequences and a sequence-position reference model under random stimulus.
module tb_multimode_counter;

    localparam int W = 4;

    logic             tb_clk;
    logic             reset_;
    logic             count_dir;
    logic             count_enable_;
    logic [1:0]       count_type;
    logic             load_;
    logic [W-1:0]     load_val;
    logic [W-1:0]     count_limit;
    logic [W-1:0]     c0, c1;
    logic             w0, w1, i0, i1;

    int n_cmp = 0;
    int n_fail = 0;

    multimode_counter #(.COUNT_WIDTH(W), .SATURATE(1'b0)) dut0 (
        .clk(tb_clk), .reset_(reset_), .count_dir(count_dir), .count_enable_(count_enable_),
        .count_type(count_type), .load_(load_), .load_val(load_val), .count_limit(count_limit),
        .count(c0), .wrap(w0), .illegal(i0)
    );

    multimode_counter #(.COUNT_WIDTH(W), .SATURATE(1'b1)) dut1 (
        .clk(tb_clk), .reset_(reset_), .count_dir(count_dir), .count_enable_(count_enable_),
        .count_type(count_type), .load_(load_), .load_val(load_val), .count_limit(count_limit),
        .count(c1), .wrap(w1), .illegal(i1)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Reference model: index 0 wraps, index 1 saturates.
    int unsigned m_count[2];
    bit          m_wrap[2];
    bit          m_ill[2];
    int unsigned m_mode;
    int unsigned jtab[2*W];

    function automatic int unsigned bin_rule(int unsigned v, int unsigned lim, bit up, bit sat,
                                             output bit w);
        w = 1'b0;
        if (up) begin
            if (v >= lim) begin w = !sat; return sat ? v : 0; end
            return v + 1;
        end
        if (v == 0) begin w = !sat; return sat ? 0 : lim; end
        return v - 1;
    endfunction

    function automatic int unsigned g2b(int unsigned g);
        int unsigned b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_count[s] = 0; m_wrap[s] = 0; m_ill[s] = 0;
        end
        m_mode = 0;
    endtask

    task automatic model_edge();
        if (!reset_) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            int unsigned nc = m_count[s];
            bit nw = 0;
            bit ni = 0;
            if (!load_) begin
                nc = load_val;
            end else if (count_type != m_mode) begin
                nc = (count_type == 2) ? 1 : 0;
            end else if (!count_enable_) begin
                case (count_type)
                    2'd0: nc = bin_rule(nc, count_limit, count_dir, s == 1, nw);
                    2'd1: begin
                        nc = bin_rule(g2b(nc), count_limit, count_dir, s == 1, nw);
                        nc = nc ^ (nc >> 1);
                    end
                    2'd2: begin
                        if ($countones(nc) != 1) begin
                            nc = 1; ni = 1;
                        end else begin
                            int idx = 0;
                            for (int k = 0; k < W; k++) if (nc == (1 << k)) idx = k;
                            if (count_dir) begin nw = (idx == 0);     idx = (idx + W - 1) % W; end
                            else           begin nw = (idx == W - 1); idx = (idx + 1) % W;     end
                            nc = 1 << idx;
                        end
                    end
                    default: begin
                        int pos = -1;
                        for (int k = 0; k < 2 * W; k++) if (jtab[k] == nc) pos = k;
                        if (pos < 0) begin
                            nc = 0; ni = 1;
                        end else begin
                            pos = count_dir ? (pos + 1) % (2 * W) : (pos + 2 * W - 1) % (2 * W);
                            nc = jtab[pos];
                            nw = (nc == 0);
                        end
                    end
                endcase
            end
            m_count[s] = nc; m_wrap[s] = nw; m_ill[s] = ni;
        end
        m_mode = count_type;
    endtask

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got count/wrap/illegal=%b/%b/%b, want %b/%b/%b at %0t",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0], $time);
        end
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge tb_clk);
        #1;
        check({tag, "/model-wrap"}, {c0, w0, i0}, {m_count[0][W-1:0], m_wrap[0], m_ill[0]});
        check({tag, "/model-sat"},  {c1, w1, i1}, {m_count[1][W-1:0], m_wrap[1], m_ill[1]});
    endtask

    task automatic drive(bit ld_n, bit en_n, bit dir, logic [1:0] typ, logic [W-1:0] val,
                         logic [W-1:0] lim);
        load_ = ld_n; count_enable_ = en_n; count_dir = dir; count_type = typ;
        load_val = val; count_limit = lim;
    endtask

    typedef struct {
        bit         ld_n;
        bit         en_n;
        bit         dir;
        logic [1:0] typ;
        logic [3:0] val;
        logic [3:0] lim;
        logic [3:0] ec;
        bit         ew;
        bit         ei;
    } vec_t;

    vec_t vq[$];

    initial begin
        for (int k = 0; k <= W; k++)     jtab[k] = ((1 << k) - 1) << (W - k);
        for (int k = W + 1; k < 2 * W; k++) jtab[k] = (1 << (2 * W - k)) - 1;

        //          ld en dir typ  val      lim      count    w  i
        vq.push_back('{0, 1, 1, 2'd0, 4'd7,    4'd9,  4'd7,    0, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd9,  4'd8,    0, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd9,  4'd9,    0, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd9,  4'd0,    1, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd9,  4'd1,    0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'd0,    0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'b0001, 0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'b0011, 0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'b0010, 0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'b0110, 0, 0});
        vq.push_back('{0, 1, 1, 2'd1, 4'b1000, 4'd15, 4'b1000, 0, 0});
        vq.push_back('{1, 0, 1, 2'd1, 4'd0,    4'd15, 4'b0000, 1, 0});
        vq.push_back('{1, 1, 1, 2'd2, 4'd0,    4'd15, 4'b0001, 0, 0});
        vq.push_back('{1, 0, 1, 2'd2, 4'd0,    4'd15, 4'b1000, 1, 0});
        vq.push_back('{1, 0, 1, 2'd2, 4'd0,    4'd15, 4'b0100, 0, 0});
        vq.push_back('{1, 0, 1, 2'd2, 4'd0,    4'd15, 4'b0010, 0, 0});
        vq.push_back('{1, 0, 1, 2'd2, 4'd0,    4'd15, 4'b0001, 0, 0});
        vq.push_back('{1, 0, 0, 2'd2, 4'd0,    4'd15, 4'b0010, 0, 0});
        vq.push_back('{0, 1, 0, 2'd2, 4'b0110, 4'd15, 4'b0110, 0, 0});
        vq.push_back('{1, 0, 1, 2'd2, 4'd0,    4'd15, 4'b0001, 0, 1});
        vq.push_back('{0, 1, 1, 2'd3, 4'b0101, 4'd15, 4'b0101, 0, 0});
        vq.push_back('{1, 0, 1, 2'd3, 4'd0,    4'd15, 4'b0000, 0, 1});
        vq.push_back('{1, 0, 1, 2'd3, 4'd0,    4'd15, 4'b1000, 0, 0});
        vq.push_back('{1, 0, 1, 2'd3, 4'd0,    4'd15, 4'b1100, 0, 0});
        vq.push_back('{1, 0, 1, 2'd3, 4'd0,    4'd15, 4'b1110, 0, 0});
        vq.push_back('{1, 0, 0, 2'd3, 4'd0,    4'd15, 4'b1100, 0, 0});
        vq.push_back('{1, 0, 0, 2'd3, 4'd0,    4'd15, 4'b1000, 0, 0});
        vq.push_back('{1, 0, 0, 2'd3, 4'd0,    4'd15, 4'b0000, 1, 0});
        vq.push_back('{1, 0, 0, 2'd0, 4'd0,    4'd5,  4'd0,    0, 0});
        vq.push_back('{1, 0, 0, 2'd0, 4'd0,    4'd5,  4'd5,    1, 0});
        vq.push_back('{1, 0, 0, 2'd0, 4'd0,    4'd5,  4'd4,    0, 0});
        vq.push_back('{1, 1, 0, 2'd0, 4'd0,    4'd5,  4'd4,    0, 0});
        vq.push_back('{0, 1, 1, 2'd0, 4'd0,    4'd0,  4'd0,    0, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd0,  4'd0,    1, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd0,  4'd0,    1, 0});
        vq.push_back('{0, 1, 1, 2'd0, 4'd12,   4'd9,  4'd12,   0, 0});
        vq.push_back('{1, 0, 1, 2'd0, 4'd0,    4'd9,  4'd0,    1, 0});
        vq.push_back('{0, 1, 1, 2'd0, 4'd12,   4'd9,  4'd12,   0, 0});
        vq.push_back('{1, 0, 0, 2'd0, 4'd0,    4'd9,  4'd11,   0, 0});

        // Reset state, asserted from time zero
        reset_ = 1'b0;
        drive(1, 1, 1, 2'd0, 4'd0, 4'd9);
        model_reset();
        #2;
        check("reset-state", {c0, w0, i0}, 6'd0);
        tick("reset-hold");
        reset_ = 1'b1;

        // Directed vectors (expected values for the wrapping instance)
        for (int v = 0; v < vq.size(); v++) begin
            drive(vq[v].ld_n, vq[v].en_n, vq[v].dir, vq[v].typ, vq[v].val, vq[v].lim);
            tick($sformatf("vec%0d", v));
            check($sformatf("vec%0d", v), {c0, w0, i0}, {vq[v].ec, vq[v].ew, vq[v].ei});
        end

        // Saturating binary down from 2: 1,0,0,0 with no wrap
        drive(0, 1, 0, 2'd0, 4'd2, 4'd9);
        tick("sat-load");
        check("sat-load", {c1, w1, i1}, {4'd2, 1'b0, 1'b0});
        begin
            logic [3:0] sat_exp [4];
            sat_exp[0] = 4'd1; sat_exp[1] = 4'd0; sat_exp[2] = 4'd0; sat_exp[3] = 4'd0;
            for (int k = 0; k < 4; k++) begin
                drive(1, 0, 0, 2'd0, 4'd0, 4'd9);
                tick($sformatf("sat-down%0d", k));
                check($sformatf("sat-down%0d", k), {c1, w1, i1}, {sat_exp[k], 1'b0, 1'b0});
            end
        end

        // Asynchronous reset between edges mid-count, then binary resumes from 0
        drive(0, 1, 1, 2'd0, 4'd5, 4'd15);
        tick("prereset-load");
        drive(1, 0, 1, 2'd0, 4'd0, 4'd15);
        tick("prereset-step");
        #2;
        reset_ = 1'b0;
        #1;
        check("async-reset-wrap", {c0, w0, i0}, 6'd0);
        check("async-reset-sat",  {c1, w1, i1}, 6'd0);
        model_reset();
        tick("reset-held");
        reset_ = 1'b1;
        tick("post-reset-step");
        check("post-reset-step", {c0, w0, i0}, {4'd1, 1'b0, 1'b0});

        // Reset release with a non-binary type reseeds on the first edge
        reset_ = 1'b0;
        #1;
        model_reset();
        drive(1, 0, 1, 2'd2, 4'd0, 4'd15);
        tick("reset-ring");
        reset_ = 1'b1;
        tick("reseed-ring");
        check("reseed-ring", {c0, w0, i0}, {4'b0001, 1'b0, 1'b0});

        // Randomized stimulus against the reference model
        for (int n = 0; n < 600; n++) begin
            load_         = ($urandom_range(0, 9) != 0);
            count_enable_ = ($urandom_range(0, 3) == 0);
            count_dir     = $urandom_range(0, 1);
            load_val      = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0)  count_type  = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) count_limit = $urandom_range(0, 15);
            if ($urandom_range(0, 99) == 0) reset_ = 1'b0;
            tick($sformatf("rand%0d", n));
            reset_ = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
